record_tx_arbiter: RTL and testbench
====================================

# record_tx_arbiter

Round-robin scheduler that shares one `uart_serialized` transmitter between `N_SRC` record FIFOs, each fed by its own `event_tagger` bank. It pops one record at a time from the next non-empty FIFO and latches it onto the transmitter input. It triggers the transmission and waits for `transmission_over`. A watchdog aborts and resets the UART if completion never arrives. It replaces per-bank FIFO-to-UART sequencing in multi-bank tagger tops.

## Interface

Parameters:
- `N_SRC`, default 2: number of record sources (2..8).
- `REC_WIDTH`, default 144: record width in bits; equals the UART `DATA_WIDTH_BYTES*8`.
- `TIMEOUT_CYCLES`, default 500000: maximum cycles spent in WAIT before abort. Must exceed one full frame; 18 bytes × 10 bits × 2604 = 468720.

Ports. Clock `clk`; reset `reset`, synchronous, active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  level. Allows new arbitration rounds.
- `src_empty`  in  N_SRC  per-FIFO empty flag.
- `src_q`  in  N_SRC*REC_WIDTH  FIFO outputs. Source i occupies `[i*REC_WIDTH +: REC_WIDTH]`. FIFOs are non-show-ahead: q is valid the cycle after rdreq.
- `src_rdreq`  out  N_SRC  one-hot read pulse.
- `tx_data`  out  REC_WIDTH  registered record to UART `data_in`.
- `tx_src`  out  max(1,clog2(N_SRC))  index of the source whose record is in `tx_data`.
- `tx_trigger`  out  1  one-cycle start pulse to UART `trigger`.
- `tx_reset`  out  1  UART reset.
- `tx_done`  in  1  UART `transmission_over`.
- `busy`  out  1  high when the state is not IDLE.
- `sent_count`  out  32  completed records, wrapping.
- `timeout_count`  out  8  aborted records, saturating at 255.

## Operation

- States and transitions:
  - IDLE → GRANT when `enable` is high and any `src_empty` bit is low.
  - GRANT → LATCH, unconditional.
  - LATCH → SEND, unconditional.
  - SEND → WAIT, unconditional.
  - WAIT → IDLE on `tx_done`. Increment `sent_count`.
  - WAIT → RECOVER when the wait counter reaches `TIMEOUT_CYCLES-1` with `tx_done` low. Increment `timeout_count` (saturating).
  - RECOVER → IDLE, unconditional.
- Arbitration in IDLE:
  - Search order is `last+1, last+2, …` modulo N_SRC. The first source with `src_empty` low wins.
  - Register the winner as `grant` and as `last`.
  - Reset value of `last` is N_SRC-1, so source 0 has first priority.
- GRANT: `src_rdreq[grant]` = 1. All other `src_rdreq` bits are 0.
- LATCH: at the end of the cycle, `tx_data` ← `src_q[grant]` and `tx_src` ← `grant`.
- SEND: `tx_trigger` = 1. `tx_data` is held stable from LATCH until the next LATCH.
- WAIT:
  - The wait counter is cleared on entry and counts WAIT cycles.
  - `tx_done` is sampled only in WAIT. A `tx_done` seen in any other state is ignored.
- RECOVER:
  - `tx_reset` = 1 for one cycle.
  - The record is dropped, not retried.
  - `last` still advances, so a stuck source cannot monopolise the link.
- `tx_reset` = `reset` OR (state == RECOVER).
- `enable` is checked only in IDLE. Dropping `enable` mid-record lets that record finish.
- Simultaneous `tx_done` and timeout terminal count: `tx_done` wins. `sent_count` increments; `timeout_count` is unchanged.
- Sources with `src_empty` high are never granted. The FIFO's own empty check is not relied on.

## Timing

- Reset values: state IDLE, `src_rdreq` 0, `tx_trigger` 0, `tx_reset` 1 while reset is high, `tx_data` 0, `tx_src` 0, `busy` 0, both counters 0, `last` N_SRC-1.
- Reset asserted in any state: return to IDLE on the next edge. No `rdreq` or trigger is issued in that cycle.
- Cycle latency, with the arbitration condition met in IDLE at cycle t:
  - `src_rdreq` high during t+1.
  - `tx_data` valid from t+3.
  - `tx_trigger` high during t+3.
  - WAIT from t+4.
- Minimum record spacing is 5 cycles plus the UART duration.
- `tx_done` high in WAIT at cycle w: IDLE at w+1; the next `rdreq` is possible at w+2.
- Timeout: RECOVER follows exactly `TIMEOUT_CYCLES` WAIT cycles; `tx_reset` is high during that cycle.
- All outputs are registered or decoded from the state register alone. None combinationally depends on `src_empty` or `tx_done`, except `tx_reset` via `reset`.

## Test plan

- Single source: N_SRC=2, FIFO0 holds `0x…A5`, FIFO1 empty, `enable`=1. Expect `rdreq[0]` at t+1, `tx_data`=`0x…A5` and `tx_src`=0 with a one-cycle trigger at t+3, and `sent_count`=1 after `tx_done`.
- Round robin: both FIFOs hold 3 records. Expect grant order 0,1,0,1,0,1, `sent_count`=6, and no `rdreq` on an empty FIFO.
- Timeout: TIMEOUT_CYCLES=20, UART model never asserts done. Expect RECOVER after 20 WAIT cycles, a one-cycle `tx_reset`, `timeout_count`=1, and the next grant going to the other source.
- Disable mid-record: drop `enable` during WAIT with records pending. Expect the current record to complete, `sent_count` +1, then IDLE with `busy`=0 and no further `rdreq`.
- Reset mid-WAIT: assert `reset` for 1 cycle. Expect IDLE, both counters 0, `tx_reset`=1 during reset, and next arbitration starting at source 0.
- Edge races:
  - A spurious `tx_done` during SEND is ignored; the record completes only on a later `tx_done`.
  - `tx_done` coinciding with the timeout terminal count gives `sent_count` +1 and `timeout_count` unchanged.

Source files
------------

// File: rtl/record_tx_arbiter.sv
// Round-robin scheduler sharing one serial transmitter between N_SRC record FIFOs.
// Pops one record from the next non-empty FIFO, latches it onto the transmitter
// input, pulses the trigger and waits for completion. A watchdog drops the record
// and resets the transmitter if completion never arrives.
//
// Handshakes: src_rdreq[i] is a one-cycle pop and src_q is sampled the following
// cycle (non-show-ahead FIFO). tx_trigger is a one-cycle start and tx_done is the
// completion strobe; tx_done counts only while waiting, and tx_data is held stable
// from the latch cycle until the next latch.
module record_tx_arbiter #(
    parameter int N_SRC          = 2,
    parameter int REC_WIDTH      = 144,
    parameter int TIMEOUT_CYCLES = 500000,
    localparam int SRC_W         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_SRC-1:0]           src_empty,
    input  logic [N_SRC*REC_WIDTH-1:0] src_q,
    output logic [N_SRC-1:0]           src_rdreq,
    output logic [REC_WIDTH-1:0]       tx_data,
    output logic [SRC_W-1:0]           tx_src,
    output logic                       tx_trigger,
    output logic                       tx_reset,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [31:0]                sent_count,
    output logic [7:0]                 timeout_count,
    output logic [2:0]                 dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [SRC_W-1:0]     grant_q;
    logic [SRC_W-1:0]     last_q;
    logic [WAIT_W-1:0]    wait_cnt_q;
    logic [REC_WIDTH-1:0] tx_data_q;
    logic [SRC_W-1:0]     tx_src_q;
    logic [31:0]          sent_q;
    logic [7:0]           tmo_q;

    logic                 win_found;
    logic [SRC_W-1:0]     win_idx;
    logic [SRC_W:0]       sum;
    logic [SRC_W-1:0]     cand;
    logic                 wait_at_tc;

    logic [REC_WIDTH-1:0] src_rec [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_split
        assign src_rec[i] = src_q[i*REC_WIDTH +: REC_WIDTH];
    end

    assign wait_at_tc = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Round-robin search starting just after the last granted source.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            sum = {1'b0, last_q} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(N_SRC)) begin
                sum = sum - (SRC_W+1)'(N_SRC);
            end
            cand = sum[SRC_W-1:0];
            if (!win_found && !src_empty[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic; tx_done wins over the watchdog terminal count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable && win_found) state_d = S_GRANT;
            S_GRANT:   state_d = S_LATCH;
            S_LATCH:   state_d = S_SEND;
            S_SEND:    state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end else if (wait_at_tc) begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State, grant bookkeeping, record latch, watchdog and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_q     <= SRC_W'(N_SRC - 1);
            wait_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_src_q   <= '0;
            sent_q     <= '0;
            tmo_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && enable && win_found) begin
                grant_q <= win_idx;
                last_q  <= win_idx;
            end
            if (state_q == S_LATCH) begin
                tx_data_q <= src_rec[grant_q];
                tx_src_q  <= grant_q;
            end
            if (state_q == S_SEND) begin
                wait_cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
            if (state_q == S_WAIT && tx_done) begin
                sent_q <= sent_q + 32'd1;
            end
            if (state_q == S_WAIT && !tx_done && wait_at_tc && tmo_q != 8'hFF) begin
                tmo_q <= tmo_q + 8'd1;
            end
        end
    end

    // Read pulse decoded from the state register; suppressed while reset is held.
    always_comb begin
        src_rdreq = '0;
        if (state_q == S_GRANT && !reset) begin
            src_rdreq[grant_q] = 1'b1;
        end
    end

    assign tx_trigger    = (state_q == S_SEND) && !reset;
    assign tx_reset      = reset || (state_q == S_RECOVER);
    assign busy          = (state_q != S_IDLE);
    assign tx_data       = tx_data_q;
    assign tx_src        = tx_src_q;
    assign sent_count    = sent_q;
    assign timeout_count = tmo_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_record_tx_arbiter.sv
// Bench for record_tx_arbiter: two modelled non-show-ahead FIFOs, a hand-driven
// transmitter done strobe, a cycle table for the single-record path and
// hand-written sequences for round robin, timeout, races, disable and reset.
module tb_record_tx_arbiter;

    localparam int N = 2;
    localparam int W = 144;
    localparam int T = 20;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic [N-1:0]   src_empty;
    logic [N*W-1:0] src_q;
    logic [N-1:0]   src_rdreq;
    logic [W-1:0]   tx_data;
    logic           tx_src;
    logic           tx_trigger;
    logic           tx_reset;
    logic           tx_done = 1'b0;
    logic           busy;
    logic [31:0]    sent_count;
    logic [7:0]     timeout_count;
    logic [2:0]     dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    record_tx_arbiter #(.N_SRC(N), .REC_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .src_empty     (src_empty),
        .src_q         (src_q),
        .src_rdreq     (src_rdreq),
        .tx_data       (tx_data),
        .tx_src        (tx_src),
        .tx_trigger    (tx_trigger),
        .tx_reset      (tx_reset),
        .tx_done       (tx_done),
        .busy          (busy),
        .sent_count    (sent_count),
        .timeout_count (timeout_count),
        .dbg_state     (dbg_state)
    );

    // ---------------- FIFO models ----------------
    logic [W-1:0] mem [N][16];
    int           push_cnt [N];
    int           pop_cnt [N];
    logic [W-1:0] q_r [N];
    int           bad_rd = 0;

    assign src_empty[0] = (push_cnt[0] == pop_cnt[0]);
    assign src_empty[1] = (push_cnt[1] == pop_cnt[1]);
    assign src_q = {q_r[1], q_r[0]};

    // Pop on rdreq; data appears the cycle after; count reads of an empty FIFO.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (src_rdreq[i]) begin
                if (push_cnt[i] == pop_cnt[i]) begin
                    bad_rd <= bad_rd + 1;
                end else begin
                    q_r[i]     <= mem[i][pop_cnt[i] % 16];
                    pop_cnt[i] <= pop_cnt[i] + 1;
                end
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    function automatic logic [W-1:0] rec(input int s, input int n);
        logic [7:0] sb;
        logic [7:0] nb;
        sb = s[7:0];
        nb = n[7:0];
        return {sb, nb, 120'h0F1E2D3C4B5A69788796A5B4C3D2E1, 8'hA5};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [W-1:0] d);
        mem[s][push_cnt[s] % 16] = d;
        push_cnt[s] = push_cnt[s] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx_reset", tx_reset, 1);
        check("rst_rdreq", src_rdreq, 0);
        check("rst_trigger", tx_trigger, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_src", tx_src, 0);
        check("rst_sent", sent_count, 0);
        check("rst_timeouts", timeout_count, 0);
        check("rst_tx_reset_low", tx_reset, 0);
    endtask

    // Waits (bounded) for the trigger, then checks the record against exp_q.
    task automatic send_check(input string name);
        bit           ok;
        logic [W-1:0] d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_trigger) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_trigger_timeout: got no trigger, required one within 40 cycles", name);
        end else begin
            d = exp_q.pop_front();
            check({name, "_data"}, tx_data, d);
            check({name, "_src"}, tx_src, d[143:136]);
        end
    endtask

    task automatic pulse_done(input int n);
        repeat (n) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // ---------------- cycle table for single-record path ----------------
    typedef struct {
        logic        done;
        logic [1:0]  rdreq;
        logic        trig;
        logic        busy;
        logic [2:0]  st;
        logic [31:0] sent;
        logic        chk_data;
    } vec_t;

    vec_t vt [8];

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p_tot;

        vt[0] = '{1'b0, 2'b00, 1'b0, 1'b0, S_IDLE,  32'd0, 1'b0};
        vt[1] = '{1'b0, 2'b01, 1'b0, 1'b1, S_GRANT, 32'd0, 1'b0};
        vt[2] = '{1'b0, 2'b00, 1'b0, 1'b1, S_LATCH, 32'd0, 1'b0};
        vt[3] = '{1'b0, 2'b00, 1'b1, 1'b1, S_SEND,  32'd0, 1'b1};
        vt[4] = '{1'b0, 2'b00, 1'b0, 1'b1, S_WAIT,  32'd0, 1'b1};
        vt[5] = '{1'b1, 2'b00, 1'b0, 1'b1, S_WAIT,  32'd0, 1'b1};
        vt[6] = '{1'b0, 2'b00, 1'b0, 1'b0, S_IDLE,  32'd1, 1'b1};
        vt[7] = '{1'b0, 2'b00, 1'b0, 1'b0, S_IDLE,  32'd1, 1'b1};

        // Single source, cycle by cycle.
        do_reset();
        enable = 1'b1;
        push(0, rec(0, 0));
        for (int r = 0; r < 8; r++) begin
            tx_done = vt[r].done;
            check($sformatf("single_r%0d_rdreq", r), src_rdreq, vt[r].rdreq);
            check($sformatf("single_r%0d_trig", r), tx_trigger, vt[r].trig);
            check($sformatf("single_r%0d_busy", r), busy, vt[r].busy);
            check($sformatf("single_r%0d_state", r), dbg_state, vt[r].st);
            check($sformatf("single_r%0d_sent", r), sent_count, vt[r].sent);
            if (vt[r].chk_data) begin
                check($sformatf("single_r%0d_data", r), tx_data, rec(0, 0));
                check($sformatf("single_r%0d_src", r), tx_src, 0);
            end
            @(negedge clk);
        end
        tx_done = 1'b0;

        // Round robin over two full FIFOs.
        enable = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push(0, rec(0, 10 + k));
            push(1, rec(1, 10 + k));
            exp_q.push_back(rec(0, 10 + k));
            exp_q.push_back(rec(1, 10 + k));
        end
        enable = 1'b1;
        for (int r = 0; r < 6; r++) begin
            send_check($sformatf("rr%0d", r));
            pulse_done(2 + r);
        end
        repeat (3) @(negedge clk);
        check("rr_sent", sent_count, 6);
        check("rr_busy", busy, 0);
        check("rr_pops0", pop_cnt[0], push_cnt[0]);
        check("rr_pops1", pop_cnt[1], push_cnt[1]);

        // Timeout: no done, then the other source is served.
        enable = 1'b0;
        do_reset();
        push(0, rec(0, 20));
        push(1, rec(1, 20));
        exp_q.push_back(rec(0, 20));
        exp_q.push_back(rec(1, 20));
        enable = 1'b1;
        send_check("tmo_first");
        for (int k = 1; k <= T; k++) begin
            @(negedge clk);
            check($sformatf("tmo_wait%0d_state", k), dbg_state, S_WAIT);
            check($sformatf("tmo_wait%0d_txrst", k), tx_reset, 0);
        end
        @(negedge clk);
        check("tmo_recover_state", dbg_state, S_RECOVER);
        check("tmo_recover_txrst", tx_reset, 1);
        check("tmo_count", timeout_count, 1);
        check("tmo_sent", sent_count, 0);
        @(negedge clk);
        check("tmo_after_txrst", tx_reset, 0);
        check("tmo_after_state", dbg_state, S_IDLE);
        send_check("tmo_next");
        pulse_done(1);
        check("tmo_next_sent", sent_count, 1);
        check("tmo_next_count", timeout_count, 1);

        // Spurious done during SEND is ignored.
        enable = 1'b0;
        do_reset();
        push(1, rec(1, 30));
        exp_q.push_back(rec(1, 30));
        enable = 1'b1;
        send_check("spur");
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("spur_state_wait", dbg_state, S_WAIT);
        repeat (2) @(negedge clk);
        check("spur_still_wait", dbg_state, S_WAIT);
        check("spur_sent_zero", sent_count, 0);
        pulse_done(1);
        check("spur_sent_one", sent_count, 1);
        check("spur_busy", busy, 0);

        // Done coinciding with the watchdog terminal count.
        enable = 1'b0;
        do_reset();
        push(0, rec(0, 40));
        exp_q.push_back(rec(0, 40));
        enable = 1'b1;
        send_check("race");
        repeat (T - 1) @(negedge clk);
        check("race_pre_state", dbg_state, S_WAIT);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("race_state", dbg_state, S_IDLE);
        check("race_sent", sent_count, 1);
        check("race_timeouts", timeout_count, 0);
        check("race_txrst", tx_reset, 0);

        // Disable mid-record: record finishes, nothing further is read.
        enable = 1'b0;
        do_reset();
        push(0, rec(0, 50));
        push(0, rec(0, 51));
        push(1, rec(1, 50));
        exp_q.push_back(rec(0, 50));
        enable = 1'b1;
        send_check("dis");
        @(negedge clk);
        enable = 1'b0;
        pulse_done(2);
        check("dis_sent", sent_count, 1);
        check("dis_busy", busy, 0);
        p_tot = pop_cnt[0] + pop_cnt[1];
        repeat (10) @(negedge clk);
        check("dis_no_rdreq", pop_cnt[0] + pop_cnt[1], p_tot);
        check("dis_idle_busy", busy, 0);
        check("dis_idle_state", dbg_state, S_IDLE);

        // Reset in the middle of WAIT.
        exp_q.push_back(rec(1, 50));
        enable = 1'b1;
        send_check("rstw");
        repeat (2) @(negedge clk);
        check("rstw_pre_state", dbg_state, S_WAIT);
        reset = 1'b1;
        #1;
        check("rstw_txrst_now", tx_reset, 1);
        @(negedge clk);
        check("rstw_state", dbg_state, S_IDLE);
        check("rstw_sent", sent_count, 0);
        check("rstw_timeouts", timeout_count, 0);
        check("rstw_txrst", tx_reset, 1);
        check("rstw_rdreq", src_rdreq, 0);
        check("rstw_trig", tx_trigger, 0);
        reset = 1'b0;
        exp_q.push_back(rec(0, 51));
        send_check("rstw_next");
        pulse_done(1);
        check("rstw_next_sent", sent_count, 1);

        repeat (3) @(negedge clk);
        check("end_pops0", pop_cnt[0], push_cnt[0]);
        check("end_pops1", pop_cnt[1], push_cnt[1]);
        check("end_bad_rdreq", bad_rd, 0);
        check("end_exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
